// File: rtl/qspi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qspi_pkg : shared types and helpers for the QSPI NOR read engine   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package qspi_pkg;

  typedef enum logic [1:0] {
    MODE_SPI = 2'd0,
    MODE_DPI = 2'd1,
    MODE_QPI = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic [2:0] lanes(input mode_e m);
    case (m)
      MODE_DPI: return 3'd2;
      MODE_QPI: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

  // Lane count is 1/2/4, so dividing by it is a right shift by the mode code.
  function automatic logic [5:0] phase_beats(input state_e st, input mode_e m,
                                             input logic [5:0] dummy);
    logic [1:0] sh;
    sh = m;
    case (st)
      ST_CMD:   return 6'd8  >> sh;
      ST_ADDR:  return 6'd24 >> sh;
      ST_DUMMY: return dummy;
      ST_DATA:  return 6'd32 >> sh;
      default:  return 6'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_nor_reader_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qspi_shifter : 32-bit parallel-load, 1/2/4-lane MSB-first shifter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module qspi_shifter
  import qspi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_load_data,
  input  logic        i_shift,
  input  mode_e       i_mode,
  input  logic [3:0]  i_din,
  output logic [3:0]  o_lanes,
  output logic [31:0] o_data
);

  logic [31:0] r_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= 32'h0;
    end else if (i_load) begin
      r_sr <= i_load_data;
    end else if (i_shift) begin
      case (i_mode)
        MODE_DPI: r_sr <= {r_sr[29:0], i_din[1:0]};
        MODE_QPI: r_sr <= {r_sr[27:0], i_din};
        default:  r_sr <= {r_sr[30:0], i_din[0]};
      endcase
    end
  end

  always_comb begin
    case (i_mode)
      MODE_DPI: o_lanes = {2'b00, r_sr[31:30]};
      MODE_QPI: o_lanes = r_sr[31:28];
      default:  o_lanes = {3'b000, r_sr[31]};
    endcase
  end

  assign o_data = r_sr;

endmodule
`default_nettype wire

// File: rtl/qspi_nor_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qspi_nor_reader : SPI/DPI/QPI NOR flash 32-bit word fetch engine   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module qspi_nor_reader
  import qspi_pkg::*;
#(
  parameter logic [7:0] OPC_SPI   = 8'h0B,
  parameter logic [7:0] OPC_DPI   = 8'hBB,
  parameter logic [7:0] OPC_QPI   = 8'hEB,
  parameter int         DUMMY_SPI = 8,
  parameter int         DUMMY_DPI = 4,
  parameter int         DUMMY_QPI = 6,
  parameter int         CSB_IDLE  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_mode,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [23:0] i_req_addr,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_qspi_sck,
  output logic        o_qspi_csb,
  output logic [3:0]  o_sio_o,
  output logic [3:0]  o_sio_oe,
  input  logic [3:0]  i_sio_i
);

  localparam logic [7:0] c_IDLE_RST    = 8'(CSB_IDLE);
  // The DONE cycle already counts as the first csb-high cycle.
  localparam logic [7:0] c_IDLE_RELOAD = 8'(CSB_IDLE - 1);

  state_e      r_state, w_next;
  mode_e       r_mode, w_req_mode;
  logic [23:0] r_addr;
  logic [6:0]  r_half;
  logic [7:0]  r_idle_cnt;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;

  logic [5:0]  w_dummy, w_beats;
  logic [7:0]  w_opc;
  logic        w_active, w_cmd_addr, w_last, w_ready, w_accept;
  logic        w_load, w_shift;
  logic [31:0] w_load_data, w_sr;
  logic [3:0]  w_din, w_lanes;

  always_comb begin
    case (i_mode)
      2'd1:    w_req_mode = MODE_DPI;
      2'd2:    w_req_mode = MODE_QPI;
      default: w_req_mode = MODE_SPI;
    endcase
    case (w_req_mode)
      MODE_DPI: w_opc = OPC_DPI;
      MODE_QPI: w_opc = OPC_QPI;
      default:  w_opc = OPC_SPI;
    endcase
    case (r_mode)
      MODE_DPI: w_dummy = 6'(DUMMY_DPI);
      MODE_QPI: w_dummy = 6'(DUMMY_QPI);
      default:  w_dummy = 6'(DUMMY_SPI);
    endcase
  end

  assign w_beats    = phase_beats(r_state, r_mode, w_dummy);
  assign w_active   = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                      (r_state == ST_DUMMY) || (r_state == ST_DATA);
  assign w_cmd_addr = (r_state == ST_CMD) || (r_state == ST_ADDR);
  // r_half counts sck half-periods in the phase; odd means sck is high.
  assign w_last     = (r_half == ({w_beats, 1'b0} - 7'd1));
  assign w_ready    = (r_state == ST_IDLE) && (r_idle_cnt == 8'd0);
  assign w_accept   = w_ready && i_req_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_CMD;
      ST_CMD:   if (w_last)   w_next = ST_ADDR;
      ST_ADDR:  if (w_last)   w_next = ST_DUMMY;
      ST_DUMMY: if (w_last)   w_next = ST_DATA;
      ST_DATA:  if (w_last)   w_next = ST_DONE;
      ST_DONE:                w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = w_ready;
    o_qspi_csb  = 1'b1;
    o_qspi_sck  = 1'b0;
    o_sio_oe    = 4'b0000;
    o_sio_o     = 4'b0000;
    if (w_active) begin
      o_qspi_csb = 1'b0;
      o_qspi_sck = r_half[0];
      case (r_mode)
        MODE_DPI: if (w_cmd_addr) begin
          o_sio_oe = 4'b0011;
          o_sio_o  = {2'b00, w_lanes[1:0]};
        end
        MODE_QPI: if (w_cmd_addr) begin
          o_sio_oe = 4'b1111;
          o_sio_o  = w_lanes;
        end
        default: begin
          // WP#/HOLD# held high; MOSI idles low outside CMD/ADDR.
          o_sio_oe = 4'b1101;
          o_sio_o  = {3'b110, w_cmd_addr & w_lanes[0]};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_half <= 7'd0;
      r_mode <= MODE_SPI;
      r_addr <= 24'h0;
    end else begin
      if (w_accept) begin
        r_mode <= w_req_mode;
        r_addr <= i_req_addr;
      end
      if (w_accept || (w_active && w_last)) r_half <= 7'd0;
      else if (w_active)                    r_half <= r_half + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_idle_cnt <= c_IDLE_RST;
    else if ((r_state == ST_DATA) && w_last)
      r_idle_cnt <= c_IDLE_RELOAD;
    else if (((r_state == ST_IDLE) || (r_state == ST_DONE)) && (r_idle_cnt != 8'd0))
      r_idle_cnt <= r_idle_cnt - 8'd1;
  end

  // Output on sck falling edges, capture on rising edges.
  assign w_load      = w_accept || ((r_state == ST_CMD) && w_last);
  assign w_load_data = (r_state == ST_IDLE) ? {w_opc, 24'h0} : {r_addr, 8'h0};
  assign w_shift     = (w_cmd_addr && r_half[0] && !w_last) ||
                       ((r_state == ST_DATA) && !r_half[0]);

  always_comb begin
    w_din = 4'b0000;
    if (r_state == ST_DATA) begin
      case (r_mode)
        MODE_DPI: w_din = {2'b00, i_sio_i[1:0]};
        MODE_QPI: w_din = i_sio_i;
        default:  w_din = {3'b000, i_sio_i[1]};
      endcase
    end
  end

  qspi_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_shift     (w_shift),
    .i_mode      (r_mode),
    .i_din       (w_din),
    .o_lanes     (w_lanes),
    .o_data      (w_sr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_rsp_valid <= (r_state == ST_DONE);
      // First byte off the wire belongs to the lowest address.
      if (r_state == ST_DONE)
        r_rsp_rdata <= {w_sr[7:0], w_sr[15:8], w_sr[23:16], w_sr[31:24]};
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_qspi_nor_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_qspi_nor_reader : directed bench with flash model + scoreboard  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_qspi_nor_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_mode = 2'd0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        qspi_sck, qspi_csb;
  logic [3:0]  sio_o, sio_oe;
  logic [3:0]  sio_i = 4'b0;

  always #5 clk = ~clk;

  qspi_nor_reader dut (
    .clk         (clk),
    .rst         (rst),
    .i_mode      (req_mode),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_qspi_sck  (qspi_sck),
    .o_qspi_csb  (qspi_csb),
    .o_sio_o     (sio_o),
    .o_sio_oe    (sio_oe),
    .i_sio_i     (sio_i)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  typedef struct {
    logic [31:0] data;
    int          mode;
    logic [23:0] addr;
    longint      t_acc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [logic [23:0]];

  function automatic logic [7:0] rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction
  function automatic int w_of(input int m);
    return (m == 1) ? 2 : (m == 2) ? 4 : 1;
  endfunction
  function automatic int dum_of(input int m);
    return (m == 1) ? 4 : (m == 2) ? 6 : 8;
  endfunction
  function automatic logic [7:0] opc_of(input int m);
    return (m == 1) ? 8'hBB : (m == 2) ? 8'hEB : 8'h0B;
  endfunction
  function automatic int lat_of(input int m);
    int w;
    w = w_of(m);
    return 2 * (8 / w + 24 / w + dum_of(m) + 32 / w) + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: push on accept, pop/compare on response, track csb-high runs.
  int n_acc = 0, n_rsp = 0, gap = 0, last_gap = -1;
  always @(negedge clk) begin
    exp_t e;
    logic [23:0] a;
    int m;
    if (!rst && req_valid && req_ready) begin
      a = req_addr;
      m = (req_mode == 2'd1) ? 1 : (req_mode == 2'd2) ? 2 : 0;
      e.data  = {rd(a + 24'd3), rd(a + 24'd2), rd(a + 24'd1), rd(a)};
      e.mode  = m;
      e.addr  = a;
      e.t_acc = cyc + 1;
      sb.push_back(e);
      n_acc++;
    end
    if (rsp_valid) begin
      chk("rsp_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rdata", 64'(rsp_rdata), 64'(e.data));
        chk("latency", 64'(cyc - e.t_acc), 64'(lat_of(e.mode)));
      end
      n_rsp++;
    end
    if (qspi_csb) gap++;
    else begin
      if (gap > 0) last_gap = gap;
      gap = 0;
    end
  end

  // Flash model: mode inferred from the first beat's enables, then checked.
  int          fm = -1, fr = 0, ff = 0, foe_err = 0;
  logic [7:0]  fcmd = 8'h0;
  logic [23:0] faddr = 24'h0;

  always @(negedge qspi_csb) begin
    fm = -1; fr = 0; ff = 0; foe_err = 0; fcmd = 8'h0; faddr = 24'h0; sio_i = 4'b0;
  end

  always @(posedge qspi_sck) begin
    int w;
    logic [3:0] ln, eoe;
    logic ca;
    if (!qspi_csb) begin
      if (fr == 0) fm = (sio_oe == 4'b0011) ? 1 : (sio_oe == 4'b1111) ? 2 : 0;
      w  = w_of(fm);
      ln = (fm == 1) ? {2'b00, sio_o[1:0]} : (fm == 2) ? sio_o : {3'b000, sio_o[0]};
      ca = (fr < 8 / w + 24 / w);
      if (fr < 8 / w) fcmd = 8'((fcmd << w) | 8'(ln));
      else if (ca)    faddr = 24'((faddr << w) | 24'(ln));
      eoe = (fm == 0) ? 4'b1101 : (fm == 1) ? (ca ? 4'b0011 : 4'b0000)
                                            : (ca ? 4'b1111 : 4'b0000);
      if (sio_oe !== eoe) foe_err++;
      if (fm == 0 && (sio_o[3:1] !== 3'b110 || (!ca && sio_o[0] !== 1'b0))) foe_err++;
      fr++;
    end
  end

  always @(negedge qspi_sck) begin
    int w, k;
    logic [31:0] word, bits;
    if (!qspi_csb && fm >= 0) begin
      w = w_of(fm);
      ff++;
      k = ff - (8 / w + 24 / w + dum_of(fm));
      if (k >= 0 && k < 32 / w) begin
        word  = {rd(faddr), rd(faddr + 24'd1), rd(faddr + 24'd2), rd(faddr + 24'd3)};
        bits  = word >> (32 - w * (k + 1));
        sio_i = 4'b0;
        case (fm)
          1:       sio_i[1:0] = bits[1:0];
          2:       sio_i      = bits[3:0];
          default: sio_i[1]   = bits[0];
        endcase
      end
    end
  end

  always @(posedge qspi_csb) begin
    if (!rst && sb.size() > 0) begin
      chk("flash_mode", 64'(fm), 64'(sb[0].mode));
      chk("opcode", 64'(fcmd), 64'(opc_of(sb[0].mode)));
      chk("address", 64'(faddr), 64'(sb[0].addr));
      chk("pad_enables", 64'(foe_err), 64'd0);
    end
  end

  task automatic wait_acc(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (n_acc >= target) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic start_req(input logic [1:0] m, input logic [23:0] a);
    int target;
    target = n_acc + 1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_mode = m; req_addr = a;
    wait_acc(target);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_mode  = (m == 2'd2) ? 2'd0 : 2'd2;
    req_addr  = ~a;
  endtask

  task automatic wait_rsp(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (n_rsp >= target) begin ok = 1'b1; break; end
    end
    chk("rsp_timeout", 64'(ok), 64'd1);
  endtask

  task automatic ready_after_reset(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (req_ready) break;
    end
    chk(tag, 64'(n), 64'd4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[24'h000100] = 8'h11; mem[24'h000101] = 8'h22;
    mem[24'h000102] = 8'h33; mem[24'h000103] = 8'h44;
    mem[24'h0000FC] = 8'hDE; mem[24'h0000FD] = 8'hAD;
    mem[24'h0000FE] = 8'hBE; mem[24'h0000FF] = 8'hEF;
    mem[24'hFFFFFE] = 8'hAA; mem[24'hFFFFFF] = 8'hBB;
    mem[24'h000000] = 8'hCC; mem[24'h000001] = 8'hDD;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb", 64'(qspi_csb), 64'd1);
    chk("rst_sck", 64'(qspi_sck), 64'd0);
    chk("rst_oe", 64'(sio_oe), 64'd0);
    chk("rst_sio_o", 64'(sio_o), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_after_reset("ready_after_por");

    start_req(2'd0, 24'h000100); wait_rsp(1);   // SPI
    start_req(2'd2, 24'h000100); wait_rsp(2);   // QPI
    start_req(2'd1, 24'h0000FC); wait_rsp(3);   // DPI
    start_req(2'd3, 24'hFFFFFE); wait_rsp(4);   // reserved mode, address wrap

    // Back-to-back with mode changed while the first is in flight.
    @(posedge clk); #1;
    req_valid = 1'b1; req_mode = 2'd0; req_addr = 24'h000100;
    wait_acc(5);
    repeat (20) @(posedge clk);
    #1 req_mode = 2'd2;
    wait_acc(6);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    chk("csb_idle_gap", 64'(last_gap), 64'd4);
    wait_rsp(6);

    // Reset 20 clk into the DATA phase of a SPI read.
    @(posedge clk); #1;
    req_valid = 1'b1; req_mode = 2'd0; req_addr = 24'h000100;
    wait_acc(7);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_csb", 64'(qspi_csb), 64'd1);
    chk("abort_sck", 64'(qspi_sck), 64'd0);
    chk("abort_oe", 64'(sio_oe), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ready_after_reset("ready_after_abort");
    repeat (160) @(posedge clk);
    chk("no_rsp_after_abort", 64'(n_rsp), 64'd6);
    start_req(2'd0, 24'h000100); wait_rsp(7);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qspi_nor_reader.md
Name: qspi_nor_reader

Overview:
- Read-only NOR flash fetch engine that drives the board qspi_sck/qspi_csb/qspi_sio pins on behalf of the SoC bus.
- Takes a 24-bit byte address and returns one 32-bit little-endian word.
- Runs in SPI (1-bit), DPI (2-bit) or QPI (4-bit) mode, selected per transaction, to match the three flash models on the simulation bench.
- Sits between the bus/XIP front end (upstream) and the pad tri-states in the wrapper (downstream).

Parameters:
- OPC_SPI, 8'h0B: fast-read opcode sent in SPI mode.
- OPC_DPI, 8'hBB: read opcode sent in DPI mode.
- OPC_QPI, 8'hEB: read opcode sent in QPI mode.
- DUMMY_SPI, 8: dummy SCK cycles in SPI mode.
- DUMMY_DPI, 4: dummy SCK cycles in DPI mode.
- DUMMY_QPI, 6: dummy SCK cycles in QPI mode.
- CSB_IDLE, 4: minimum clk cycles csb stays high between transactions.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mode  in  2  0=SPI, 1=DPI, 2=QPI, 3=reserved (treated as SPI); sampled at request accept.
- req_valid  in  1  read request.
- req_ready  out  1  request accepted when valid&&ready.
- req_addr  in  24  byte address.
- rsp_valid  out  1  one-cycle pulse, rdata valid.
- rsp_rdata  out  32  read data; byte at addr in [7:0].
- qspi_sck  out  1  serial clock, clk/2.
- qspi_csb  out  1  chip select, active low.
- sio_o  out  4  pad output data.
- sio_oe  out  4  pad output enable, per line.
- sio_i  in  4  pad input data.

Behaviour:
- **Reset values:** csb=1, sck=0, sio_oe=0, sio_o=0, req_ready=0, rsp_valid=0, rsp_rdata=0. The FSM enters IDLE with the CSB_IDLE counter preloaded, so req_ready rises CSB_IDLE cycles after rst deasserts.
- **Reset mid-transaction:** the transaction is aborted, no rsp pulse is issued, and csb goes high on the next edge.
- **States:** IDLE -> CMD -> ADDR -> DUMMY -> DATA -> DONE -> IDLE.
- **Accept:** req_ready=1 only in IDLE with the idle counter expired. On accept, latch addr and mode, drop csb, go to CMD with sck=0.
- **SCK timing:** sck toggles every clk while in CMD/ADDR/DUMMY/DATA.
  - The controller updates sio_o on clk edges where sck goes 1->0 (and on entry).
  - It samples sio_i on the edge where sck goes 0->1.
  - Each phase is a whole number of sck periods, and sck ends low.
- **Lane width W:** W = 1/2/4 for SPI/DPI/QPI. Per sck period, the beats per phase are:
  - CMD: 8/W beats, MSB first. SPI uses sio[0]; DPI uses sio[1:0] (bit1=MSB of pair); QPI uses sio[3:0].
  - ADDR: 24/W beats, MSB first, same lanes.
  - DUMMY: DUMMY_x beats. sio_oe=0 for DPI/QPI. In SPI, sio_oe[0] stays 1 with sio_o=0.
  - DATA: 32/W beats, sio_oe=0. SPI samples sio_i[1]; DPI samples sio_i[1:0]; QPI samples sio_i[3:0].
- **sio_oe per mode:** SPI drives oe=4'b1101 with sio[3:2]=1 (WP#/HOLD# high) for the whole transaction; sio[1] is never driven. DPI drives oe=4'b0011 in CMD/ADDR. QPI drives oe=4'b1111 in CMD/ADDR.
- **Data assembly:** shift into an MSB-first byte shift register. Completed bytes fill rsp_rdata[7:0], then [15:8], [23:16], [31:24].
- **DONE:** the cycle after the last sampling edge, csb=1, sck=0, oe=0, and rsp_valid pulses for 1 cycle. Reload the CSB_IDLE counter and return to IDLE.
- **Latency:** accept to rsp_valid = 2*(8/W + 24/W + DUMMY + 32/W) + 1 clk.
  - SPI: 2*(8+24+8+32)+1 = 145.
  - QPI: 2*(2+6+6+8)+1 = 45.
- **Address wrap:** addr 24'hFFFFFE reads bytes FFFFFE, FFFFFF, 000000, 000001. The flash wraps internally; no special logic is needed.
- **Mode/addr changes:** changes to mode or req_addr while busy have no effect.
- **Reserved mode:** mode=3 behaves exactly as SPI.
- **Back-to-back requests:** req_valid held high produces consecutive transactions separated by CSB_IDLE cycles of csb high.

Decomposition:
- Package qspi_pkg:
  - mode enum: MODE_SPI, MODE_DPI, MODE_QPI.
  - FSM state enum.
  - Function lanes(mode) returning W.
  - Function phase_beats(state, mode).
- One sub-module, qspi_shifter: a 32-bit parallel-load, W-lane shift register used for both the CMD/ADDR output and the DATA input.
- The FSM and beat counter stay in the top module.

Test Plan:
- **SPI read:** flash bytes @0x000100 = 11 22 33 44, mode=0, addr=0x000100.
  - rsp_rdata=0x44332211 exactly 145 clk after accept.
  - First 8 sio_o[0] bits = 0x0B.
  - sio_oe=4'b1101 throughout.
- **QPI read:** mode=2, addr=0x000100.
  - Same data, latency 45 clk.
  - CMD nibbles A=E, B; address nibbles 000100.
  - oe=0 during DUMMY and DATA.
- **DPI read:** mode=1, addr=0x0000FC, flash FC..FF = DE AD BE EF.
  - rdata=0xEFBEADDE.
  - Opcode pairs 10 11 10 11 (0xBB).
- **Wrap:** addr=0xFFFFFE, flash FFFFFE..FFFFFF = AA BB, 000000..000001 = CC DD, any mode.
  - rdata=0xDDCCBBAA.
- **Back-to-back and mode latch:** 2 requests with req_valid held; mode toggled 0->2 mid-first-transaction.
  - First transaction completes as SPI.
  - csb high for exactly CSB_IDLE=4 clk between transactions.
  - Second transaction runs as QPI.
- **Reset mid-DATA:** assert rst 20 clk into a SPI read.
  - Next edge: csb=1, sck=0, oe=0.
  - No rsp_valid is issued.
  - req_ready returns 4 clk after rst deasserts, and a new read then returns correct data.
